// File: rtl/uart_tx_fifo.sv
// Byte-wide UART transmitter (8N1, LSB first) fed from a small valid/ready FIFO.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // FIFO: pointers carry one extra MSB so full and empty are distinguishable
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, empty, push, pop;
  logic [7:0]  head;

  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty      = (wptr == rptr);
  assign push       = tx_valid && !full;
  assign head       = mem[rptr[AW-1:0]];
  assign tx_ready   = !full;
  assign fifo_count = wptr - rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= tx_data;
  end

  // Serialiser
  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shift, shift_d;
  logic          tx_q, tx_d;
  logic          load, bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign bit_end = (cnt == CNT_LAST);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    shift_d = shift;
    tx_d    = tx_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        load  = !empty;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = shift[0];
          shift_d = shift >> 1;
          bit_d   = 3'd0;
          state_d = DATA;
        end else cnt_d = cnt + 1'b1;
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            tx_d    = shift[0];
            shift_d = shift >> 1;
            bit_d   = bit_idx + 1'b1;
          end
        end else cnt_d = cnt + 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else cnt_d = cnt + 1'b1;
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = IDLE;
          load    = !empty;   // back-to-back frames: no idle bit in between
        end else cnt_d = cnt + 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
    if (load) begin
      shift_d = head;
      tx_d    = 1'b0;
      state_d = START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  assign pop = load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shift   <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_out = tx_q;
  assign busy   = (state != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks per bit with a 4-entry FIFO.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_out, busy;
  logic [2:0] fifo_count;

  int tests = 0;
  int fails = 0;

  uart_tx_fifo #(.CLK_HZ(400), .BAUD(100), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called on the negedge just before the edge that drives the start bit.
  task automatic check_frame(input logic [7:0] d, input logic p, input string tag);
    logic e, ok, bad;
    for (int b = 0; b < NB; b++) begin
      if (b == 0)                  e = 1'b0;
      else if (b <= 8)             e = d[b-1];
      else if (NB == 11 && b == 9) e = p;
      else                         e = 1'b1;
      ok  = 1'b1;
      bad = e;
      repeat (4) begin
        @(negedge clk);
        if (tx_out !== e || busy !== 1'b1) begin
          ok  = 1'b0;
          bad = tx_out;
        end
      end
      chk($sformatf("%s bit%0d (line=%0b busy/line ok)", tag, b, bad), ok, 1);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    string      name;
  } vec_t;
  vec_t vecs[6];

  logic [7:0] burst[6];
  logic       burst_rdy[6];

  initial begin
    vecs[0] = '{8'h55, 1'b0, "v55"};
    vecs[1] = '{8'h00, 1'b0, "v00"};
    vecs[2] = '{8'hFF, 1'b0, "vFF"};
    vecs[3] = '{8'h80, 1'b1, "v80"};
    vecs[4] = '{8'h07, 1'b1, "v07"};
    vecs[5] = '{8'h03, 1'b0, "v03"};
    burst     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    burst_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    #1;
    chk("reset tx_out", tx_out, 1);
    chk("reset tx_ready", tx_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset fifo_count", fifo_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single frames from idle
    for (int i = 0; i < 6; i++) begin
      tx_data = vecs[i].data; tx_valid = 1'b1;
      chk({vecs[i].name, " ready"}, tx_ready, 1);
      @(negedge clk);
      tx_valid = 1'b0;
      chk({vecs[i].name, " not yet low"}, tx_out, 1);
      chk({vecs[i].name, " count"}, fifo_count, 1);
      chk({vecs[i].name, " busy"}, busy, 1);
      check_frame(vecs[i].data, vecs[i].par, vecs[i].name);
      @(negedge clk);
      chk({vecs[i].name, " busy after"}, busy, 0);
      chk({vecs[i].name, " idle line"}, tx_out, 1);
      chk({vecs[i].name, " empty"}, fifo_count, 0);
    end

    // three back-to-back frames, no gap
    tx_data = 8'hA3; tx_valid = 1'b1;
    fork
      begin
        @(negedge clk) tx_data = 8'h0F;
        @(negedge clk) tx_data = 8'hFF;
        @(negedge clk) tx_valid = 1'b0;
      end
      begin
        @(negedge clk);
        check_frame(8'hA3, 1'b0, "b2b A3");
        check_frame(8'h0F, 1'b0, "b2b 0F");
        check_frame(8'hFF, 1'b0, "b2b FF");
      end
    join
    @(negedge clk);
    chk("b2b busy after", busy, 0);

    // push on the last STOP clock: one idle bit-clock, then the next frame
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check_frame(8'h5A, 1'b0, "gap 5A");
    tx_data = 8'hC1; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("gap line high", tx_out, 1);
    chk("gap count", fifo_count, 1);
    check_frame(8'hC1, 1'b1, "gap C1");
    @(negedge clk);
    chk("gap busy after", busy, 0);

    // fill: 1 on the wire + 4 queued, 6th dropped
    fork
      begin
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
          tx_data = burst[i];
          chk($sformatf("fill ready %0d", i), tx_ready, burst_rdy[i]);
          @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("fill count", fifo_count, 4);
        chk("fill ready full", tx_ready, 0);
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 5; i++) check_frame(burst[i], 1'b0, $sformatf("fill %0h", burst[i]));
      end
    join
    begin
      logic ok;
      ok = 1'b1;
      repeat (40) begin
        @(negedge clk);
        if (tx_out !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      chk("fill dropped byte not sent", ok, 1);
    end

    // reset during DATA of 0x3C with 0x81 queued
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk) tx_data = 8'h81;
    @(negedge clk) tx_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre-reset count", fifo_count, 1);
    chk("pre-reset busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("async rst tx_out", tx_out, 1);
    chk("async rst count", fifo_count, 0);
    chk("async rst busy", busy, 0);
    chk("async rst ready", tx_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic ok;
      ok = 1'b1;
      repeat (60) begin
        @(negedge clk);
        if (tx_out !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      chk("no resume after reset", ok, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
